audio_sample_pacer: RTL and testbench



---
 rtl/audio_sample_pacer_if.sv | 26 ++
 rtl/audio_sample_pacer.sv | 112 +++++++++++
 tb/tb_audio_sample_pacer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_sample_pacer_if.sv
// Audio pacer bus: FIFO read side plus the sample/clock outputs toward the HDMI core.
// The pacer takes the slave modport; whatever feeds the FIFO flags and consumes audio takes master.
interface audio_sample_pacer_if #(
    parameter int unsigned WNUM_W = 11
);
    logic [31:0]       fifo_q;
    logic              fifo_empty;
    logic [WNUM_W-1:0] fifo_wnum;
    logic              fifo_rden;
    logic              mute;
    logic              clk_audio;
    logic [15:0]       audio_left;
    logic [15:0]       audio_right;
    logic              playing;
    logic [15:0]       underrun_count;

    modport master (
        output fifo_q, fifo_empty, fifo_wnum, mute,
        input  fifo_rden, clk_audio, audio_left, audio_right, playing, underrun_count
    );

    modport slave (
        input  fifo_q, fifo_empty, fifo_wnum, mute,
        output fifo_rden, clk_audio, audio_left, audio_right, playing, underrun_count
    );
endinterface

// File: rtl/audio_sample_pacer.sv
// Paces stereo samples out of the audio FIFO at SAMPLE_HZ using a fractional accumulator
// on clk_pixel; handles pre-fill, underrun hold, mute and re-priming after starvation.
module audio_sample_pacer #(
    parameter int unsigned CLK_HZ         = 75000000,
    parameter int unsigned SAMPLE_HZ      = 48000,
    parameter int unsigned PRIME_LEVEL    = 256,
    parameter int unsigned UNDERRUN_LIMIT = 64,
    parameter int unsigned WNUM_W         = 11
) (
    input  logic          clk_pixel,
    input  logic          reset,
    audio_sample_pacer_if.slave bus
);
    localparam logic [31:0]       CLK_W   = 32'(CLK_HZ);
    localparam logic [31:0]       STEP_W  = 32'(SAMPLE_HZ);
    localparam logic [31:0]       HALF_W  = 32'(CLK_HZ / 2);
    localparam logic [WNUM_W-1:0] PRIME_W = WNUM_W'(PRIME_LEVEL);
    localparam logic [15:0]       LIMIT_W = 16'(UNDERRUN_LIMIT);

    typedef enum logic {ST_PRIME, ST_RUN} state_t;

    state_t      state, state_next;
    logic [31:0] acc, acc_sum, acc_next;
    logic        tick;
    logic        rden, rd_pend, underrun;
    logic [31:0] held, held_next;
    logic [15:0] consec, consec_next;
    logic [15:0] under_cnt;
    logic        clk_audio_q;
    logic [15:0] left_q, right_q;

    always_comb begin
        acc_sum  = acc + STEP_W;
        tick     = (acc_sum >= CLK_W);
        acc_next = tick ? (acc_sum - CLK_W) : acc_sum;
    end

    always_comb begin
        state_next  = state;
        rden        = 1'b0;
        underrun    = 1'b0;
        held_next   = rd_pend ? bus.fifo_q : held;
        consec_next = rd_pend ? '0 : consec;
        case (state)
            ST_PRIME: begin
                // The tick that leaves PRIME is already a RUN tick: it reads or counts an underrun.
                if (tick && (bus.fifo_wnum >= PRIME_W)) begin
                    state_next = ST_RUN;
                    rden       = !bus.fifo_empty;
                    underrun   = bus.fifo_empty;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    rden     = !bus.fifo_empty;
                    underrun = bus.fifo_empty;
                end
            end
            default: state_next = ST_PRIME;
        endcase
        if (underrun) begin
            if (consec_next >= LIMIT_W - 16'd1) begin
                state_next  = ST_PRIME;
                consec_next = '0;
            end else begin
                consec_next = consec_next + 16'd1;
            end
        end
        if (reset) begin
            rden = 1'b0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            acc         <= '0;
            state       <= ST_PRIME;
            held        <= '0;
            consec      <= '0;
            under_cnt   <= '0;
            rd_pend     <= 1'b0;
            clk_audio_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
        end else begin
            acc         <= acc_next;
            state       <= state_next;
            held        <= held_next;
            consec      <= consec_next;
            rd_pend     <= rden;
            clk_audio_q <= (acc >= HALF_W);
            if (underrun && (under_cnt != 16'hFFFF)) begin
                under_cnt <= under_cnt + 16'd1;
            end
            // Output register follows the sample being captured this cycle, not the stale one.
            if ((state_next == ST_RUN) && !bus.mute) begin
                left_q  <= held_next[31:16];
                right_q <= held_next[15:0];
            end else begin
                left_q  <= '0;
                right_q <= '0;
            end
        end
    end

    assign bus.fifo_rden      = rden;
    assign bus.clk_audio      = clk_audio_q;
    assign bus.audio_left     = left_q;
    assign bus.audio_right    = right_q;
    assign bus.playing        = (state == ST_RUN);
    assign bus.underrun_count = under_cnt;
endmodule

// File: tb/tb_audio_sample_pacer.sv
// Bench for audio_sample_pacer: queue-backed FIFO, arithmetic tick/transaction model,
// directed prime/underrun/mute/reset phases followed by randomized traffic.
module tb_audio_sample_pacer;
    localparam int unsigned C  = 100;
    localparam int unsigned SA = 10;
    localparam int unsigned SB = 30;
    localparam int unsigned PL = 4;
    localparam int unsigned UL = 4;
    localparam int unsigned WW = 11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    audio_sample_pacer_if #(.WNUM_W(WW)) a ();
    audio_sample_pacer_if #(.WNUM_W(WW)) b ();

    audio_sample_pacer #(
        .CLK_HZ(C), .SAMPLE_HZ(SA), .PRIME_LEVEL(PL), .UNDERRUN_LIMIT(UL), .WNUM_W(WW)
    ) dut_a (
        .clk_pixel(clk), .reset(reset), .bus(a.slave)
    );

    audio_sample_pacer #(
        .CLK_HZ(C), .SAMPLE_HZ(SB), .WNUM_W(WW)
    ) dut_b (
        .clk_pixel(clk), .reset(reset), .bus(b.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: cycle index since reset, play flag, held word, counters.
    longint      n;
    bit          m_play, m_pend, m_clk;
    logic [31:0] m_held;
    int          m_consec, m_under;
    logic [15:0] m_l, m_r;
    logic [31:0] fq[$];
    int          push_pct = 0;
    int          rd_cnt = 0;
    bit          act_rd;

    bit     b_win = 1'b1;
    int     b_rd = 0, b_rise = 0;
    bit     b_prev = 1'b0;
    longint b_last = -1;

    function automatic bit tick_at(input longint k);
        return (((k + 1) * SA) / C) != ((k * SA) / C);
    endfunction

    task automatic model_reset();
        n = 0; m_play = 0; m_pend = 0; m_clk = 0; m_held = '0;
        m_consec = 0; m_under = 0; m_l = '0; m_r = '0;
    endtask

    task automatic fifo_flags();
        a.fifo_empty = (fq.size() == 0);
        a.fifo_wnum  = WW'(fq.size());
    endtask

    task automatic fifo_put(input logic [31:0] w);
        fq.push_back(w);
        fifo_flags();
    endtask

    task automatic step();
        bit tk, exp_rd, go;
        @(negedge clk);
        tk     = tick_at(n);
        go     = tk && (m_play || (a.fifo_wnum >= PL));
        exp_rd = !reset && go && !a.fifo_empty;
        act_rd = a.fifo_rden;
        check_eq("rden", act_rd, exp_rd);
        check_eq("left", a.audio_left, m_l);
        check_eq("right", a.audio_right, m_r);
        check_eq("clk_audio", a.clk_audio, m_clk);
        check_eq("playing", a.playing, m_play);
        check_eq("underrun_count", a.underrun_count, m_under);
        if (act_rd) rd_cnt++;
        if (b_win) begin
            if (n < 1000 && b.fifo_rden) begin
                b_rd++;
                if (b_last >= 0) check_eq("b_tick_gap", ((n - b_last) == 3) || ((n - b_last) == 4), 1);
                b_last = n;
            end
            if (n <= 1000 && b.clk_audio && !b_prev) b_rise++;
            b_prev = b.clk_audio;
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (m_pend) begin
                m_held   = a.fifo_q;
                m_consec = 0;
            end
            if (go) begin
                m_play = 1;
                if (a.fifo_empty) begin
                    if (m_under < 65535) m_under++;
                    m_consec++;
                    if (m_consec >= UL) begin
                        m_play   = 0;
                        m_consec = 0;
                    end
                end
            end
            m_pend = exp_rd;
            if (m_play && !a.mute) begin
                m_l = m_held[31:16];
                m_r = m_held[15:0];
            end else begin
                m_l = '0;
                m_r = '0;
            end
            m_clk = ((n * SA) % C) >= (C / 2);
            n++;
        end
        #1;
        if (act_rd) a.fifo_q = (fq.size() > 0) ? fq.pop_front() : 32'hDEAD_DEAD;
        if (push_pct > 0 && $urandom_range(99) < push_pct && fq.size() < 1000)
            fq.push_back($urandom());
        fifo_flags();
    endtask

    initial begin
        int r0;
        reset = 1'b1;
        a.mute = 1'b0; a.fifo_q = '0; a.fifo_empty = 1'b1; a.fifo_wnum = '0;
        b.mute = 1'b0; b.fifo_q = '0; b.fifo_empty = 1'b0; b.fifo_wnum = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_left", a.audio_left, 0);
        check_eq("rst_right", a.audio_right, 0);
        check_eq("rst_clk_audio", a.clk_audio, 0);
        check_eq("rst_playing", a.playing, 0);
        check_eq("rst_underrun", a.underrun_count, 0);
        check_eq("rst_rden", a.fifo_rden, 0);

        // Below prime level: three ticks pass with no read.
        repeat (3) fifo_put(32'h1234_ABCD);
        reset = 1'b0;
        repeat (30) step();
        check_eq("prime_no_read", rd_cnt, 0);
        fifo_put(32'h1234_ABCD);
        for (int i = 0; i < 30 && rd_cnt == 0; i++) step();
        check_eq("prime_first_read", rd_cnt, 1);
        step();
        check_eq("first_left", a.audio_left, 16'h1234);
        check_eq("first_right", a.audio_right, 16'hABCD);
        check_eq("first_playing", a.playing, 1);

        // Drain, then three starved ticks hold the last sample.
        for (int i = 0; i < 100 && a.underrun_count != 16'd3; i++) step();
        check_eq("hold_underrun", a.underrun_count, 3);
        check_eq("hold_left", a.audio_left, 16'h1234);
        check_eq("hold_right", a.audio_right, 16'hABCD);
        check_eq("hold_reads", rd_cnt, 4);
        fifo_put(32'h5555_AAAA);
        r0 = rd_cnt;
        for (int i = 0; i < 20 && rd_cnt == r0; i++) step();
        check_eq("refill_read", rd_cnt - r0, 1);
        for (int i = 0; i < 100 && a.playing; i++) step();
        check_eq("reprime_playing", a.playing, 0);
        check_eq("reprime_underrun", a.underrun_count, 7);
        check_eq("reprime_left", a.audio_left, 0);

        // Muted playback still drains the FIFO.
        a.mute = 1'b1;
        repeat (8) fifo_put($urandom());
        for (int i = 0; i < 30 && !a.playing; i++) step();
        check_eq("mute_playing", a.playing, 1);
        r0 = rd_cnt;
        repeat (40) step();
        check_eq("mute_reads", rd_cnt - r0, 4);
        check_eq("mute_left", a.audio_left, 0);
        a.mute = 1'b0;
        step();
        check_eq("unmute_left", a.audio_left, m_held[31:16]);
        check_eq("unmute_right", a.audio_right, m_held[15:0]);

        while (n <= 1001) step();
        b_win = 1'b0;
        check_eq("b_ticks_1000", b_rd, 300);
        check_eq("b_clk_audio_rises", b_rise, 300);

        // Reset lands in the cycle after a read; the pending capture must be dropped.
        repeat (8) fifo_put($urandom());
        act_rd = 1'b0;
        for (int i = 0; i < 40 && !act_rd; i++) step();
        check_eq("midreset_read_seen", act_rd, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midreset_playing", a.playing, 0);
        check_eq("midreset_left", a.audio_left, 0);
        check_eq("midreset_underrun", a.underrun_count, 0);

        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(3))
                0: push_pct = 1;
                1: push_pct = 6;
                2: push_pct = 12;
                default: push_pct = 30;
            endcase
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(99) < 3) a.mute = ~a.mute;
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
